// File: rtl/e5a2_arb.sv
// e5a2_arb -- 8-way arbiter with fixed-priority / round-robin selection and
// a hold counter that forces preemption after MAXHOLD consecutive grant cycles.
//
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst   : asynchronous active-high reset
//   req   : level-sensitive requests, req[k] belongs to requester k
//   mode  : 0 = fixed priority (7 highest), 1 = round-robin
//   gnt   : registered one-hot grant
//   gid   : registered encoded owner, requester k reported as 7-k
//   valid : registered, high exactly when gnt is nonzero
module e5a2_arb #(
  parameter int MAXHOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       mode,
  output logic [7:0] gnt,
  output logic [2:0] gid,
  output logic       valid
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] HMAX = 8'(MAXHOLD);

  state_t     state_q, state_d;
  logic [2:0] owner_q, owner_d;
  logic [2:0] last_q, last_d;
  logic [7:0] hcnt_q, hcnt_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] gid_q, gid_d;
  logic       valid_q, valid_d;

  logic       arb;
  logic [7:0] cand;
  logic [7:0] others;
  logic [2:0] start;
  logic [3:0] pick_res;

  // Saturating increment of the hold counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v >= HMAX) ? HMAX : v + 8'd1;
  endfunction

  // Scan downward from 'start', wrapping 0 -> 7; returns {found, index}.
  function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] s);
    logic       found;
    logic [2:0] win;
    logic [2:0] idx;
    found = 1'b0;
    win   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = s - 3'(i);
      if (!found && r[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    hcnt_d  = hcnt_q;
    gnt_d   = gnt_q;
    gid_d   = gid_q;
    valid_d = valid_q;
    arb     = 1'b0;
    cand    = req;
    // mode only matters when arb is raised, so it is effectively sampled at
    // arbitration edges and never disturbs a sitting owner.
    start   = mode ? (last_q - 3'd1) : 3'd7;
    others  = req & ~(8'd1 << owner_q);

    case (state_q)
      IDLE: begin
        if (|req) begin
          arb = 1'b1;
        end else begin
          gnt_d   = 8'h00;
          valid_d = 1'b0;
        end
      end
      BUSY: begin
        if (!req[owner_q]) begin
          // Owner released: hand over in the same edge, no idle bubble.
          if (|others) begin
            arb  = 1'b1;
            cand = others;
          end else begin
            state_d = IDLE;
            gnt_d   = 8'h00;
            valid_d = 1'b0;
            hcnt_d  = 8'd0;
          end
        end else if (hcnt_q >= HMAX && |others) begin
          // Hold limit reached with competition: preempt, owner excluded.
          arb  = 1'b1;
          cand = others;
        end else begin
          hcnt_d = sat_inc(hcnt_q);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    pick_res = pick(cand, start);
    if (arb && pick_res[3]) begin
      state_d = BUSY;
      owner_d = pick_res[2:0];
      last_d  = pick_res[2:0];
      hcnt_d  = 8'd1;
      gnt_d   = 8'd1 << pick_res[2:0];
      gid_d   = ~pick_res[2:0];
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 3'd0;
      last_q  <= 3'd0;
      hcnt_q  <= 8'd0;
      gnt_q   <= 8'h00;
      gid_q   <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hcnt_q  <= hcnt_d;
      gnt_q   <= gnt_d;
      gid_q   <= gid_d;
      valid_q <= valid_d;
    end
  end

  assign gnt   = gnt_q;
  assign gid   = gid_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_e5a2_arb.sv
module tb_e5a2_arb;

  localparam int MAXHOLD = 8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       mode;
  logic [7:0] gnt;
  logic [2:0] gid;
  logic       valid;

  e5a2_arb #(.MAXHOLD(MAXHOLD)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .mode (mode),
    .gnt  (gnt),
    .gid  (gid),
    .valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] gid;
    logic       valid;
    int         hcnt;
  } exp_t;

  exp_t exp_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  bit m_busy;
  int m_own;
  int m_last;
  int m_hcnt;
  int m_gid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_own = 0; m_last = 0; m_hcnt = 0; m_gid = 0;
  endtask

  task automatic model_grant(input logic [7:0] r, input logic m);
    int s;
    int c;
    s = m ? ((m_last + 7) % 8) : 7;
    for (int k = 0; k < 8; k++) begin
      c = (s - k + 8) % 8;
      if (r[c]) begin
        m_busy = 1; m_own = c; m_last = c; m_hcnt = 1; m_gid = 7 - c;
        return;
      end
    end
  endtask

  task automatic model_step(input logic [7:0] r, input logic m);
    logic [7:0] rest;
    exp_t e;
    if (!m_busy) begin
      if (r != 8'h00) model_grant(r, m);
    end else begin
      rest = r;
      rest[m_own] = 1'b0;
      if (!r[m_own]) begin
        if (rest != 8'h00) model_grant(rest, m);
        else begin m_busy = 0; m_hcnt = 0; end
      end else if (m_hcnt == MAXHOLD) begin
        if (rest != 8'h00) model_grant(rest, m);
      end else begin
        m_hcnt++;
      end
    end
    e.gnt   = m_busy ? (8'h01 << m_own) : 8'h00;
    e.gid   = 3'(m_gid);
    e.valid = m_busy;
    e.hcnt  = m_hcnt;
    exp_q.push_back(e);
  endtask

  // drive one cycle: inputs set away from the edge, output compared #1 after it
  task automatic cycle(input logic [7:0] r, input logic m);
    exp_t e;
    req  = r;
    mode = m;
    model_step(r, m);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("gnt", 32'(gnt), 32'(e.gnt));
      chk("gid", 32'(gid), 32'(e.gid));
      chk("valid", 32'(valid), 32'(e.valid));
      chk("hcnt", 32'(dut.hcnt_q), 32'(e.hcnt));
    end
  endtask

  initial begin
    logic [7:0] r;
    logic       m;
    rst  = 1'b1;
    req  = 8'h00;
    mode = 1'b0;
    model_reset();
    #2;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_gid", 32'(gid), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // idle with no requests
    for (int i = 0; i < 4; i++) cycle(8'h00, 1'b0);

    // fixed priority: 0010_0100 -> requester 5
    cycle(8'h24, 1'b0);
    chk("fixed_gnt", 32'(gnt), 32'h20);
    chk("fixed_gid", 32'(gid), 32'h2);
    cycle(8'h00, 1'b0);

    // round-robin with all requests held: 7,6,...,0,7 each for MAXHOLD cycles
    for (int i = 0; i < 9 * MAXHOLD + 2; i++) cycle(8'hFF, 1'b1);
    cycle(8'h00, 1'b1);

    // release hand-over without bubble: owner 3 drops, 1 takes over
    cycle(8'h0A, 1'b0);
    chk("own3", 32'(gnt), 32'h08);
    cycle(8'h0A, 1'b0);
    cycle(8'h02, 1'b0);
    chk("handover_gnt", 32'(gnt), 32'h02);
    chk("handover_valid", 32'(valid), 32'h1);
    cycle(8'h00, 1'b0);

    // lone requester held: no preemption, counter saturates
    for (int i = 0; i < 20; i++) cycle(8'h01, 1'b1);
    chk("sat_hcnt", 32'(dut.hcnt_q), 32'(MAXHOLD));
    cycle(8'h00, 1'b1);

    // random traffic with sticky requests and mode flips
    r = 8'h00;
    m = 1'b0;
    for (int i = 0; i < 300; i++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      if ($urandom_range(0, 15) == 0) m = ~m;
      cycle(r, m);
    end

    // asynchronous reset in the middle of a grant
    cycle(8'h10, 1'b0);
    cycle(8'h10, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_gnt", 32'(gnt), 32'h0);
    chk("async_valid", 32'(valid), 32'h0);
    chk("async_gid", 32'(gid), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cycle(8'h81, 1'b1);
    chk("post_rst_gnt", 32'(gnt), 32'h80);
    for (int i = 0; i < 3; i++) cycle(8'h81, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/e5a2_arb.md
E5A2_ARB -- requirements
Module: e5a2_arb

Interface
REQ-001 SHALL have parameter MAXHOLD, default 8, meaning the maximum number of consecutive grant cycles before forced preemption; legal range 2..255.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port req, input, 8 bits: request from requester k on req[k], level-sensitive, held high while the requester needs the shared resource.
REQ-005 SHALL have port mode, input, 1 bit: 0 = fixed priority, 1 = round-robin.
REQ-006 SHALL have port gnt, output, 8 bits: registered one-hot grant, gnt[k] = requester k owns the resource.
REQ-007 SHALL have port gid, output, 3 bits: registered encoded owner, requester k encoded as 7-k (req[7] -> 3'b000, req[0] -> 3'b111).
REQ-008 SHALL have port valid, output, 1 bit: registered, high exactly when gnt is nonzero.

Function
REQ-009 SHALL implement two states, IDLE (no owner) and BUSY (one owner), with gnt at most one-hot in every cycle.
REQ-010 SHALL, in fixed mode, select the winner by priority index 7 (highest) down to 0.
REQ-011 SHALL, in round-robin mode, search from index last-1 downward, wrapping 0 -> 7, where last is the most recently granted index.
REQ-012 SHALL, in IDLE with any req bit high at a rising edge, enter BUSY and assert gnt/gid/valid for the winner at that edge (1-cycle latency from req to gnt).
REQ-013 SHALL, in IDLE with req = 0, stay IDLE with gnt = 0, valid = 0, gid unchanged.
REQ-014 SHALL keep the owner in BUSY while req[owner] = 1 and the hold counter has not expired.
REQ-015 SHALL maintain hold counter hcnt: load 1 on every new grant, increment each BUSY cycle the owner is kept, and saturate at MAXHOLD.
REQ-016 SHALL, when req[owner] = 0 at an edge, release the owner at that edge and, in the same edge, grant the winner among the remaining req bits (owner excluded) with no idle bubble; with no other request, go to IDLE.
REQ-017 SHALL, when hcnt = MAXHOLD and another req bit is high, preempt at that edge and grant the winner with the owner excluded; the preempted requester re-competes normally afterwards.
REQ-018 SHALL, when hcnt = MAXHOLD and no other req bit is high, keep the owner with hcnt saturated.
REQ-019 SHALL update last to the new owner index on every grant, in both modes.
REQ-020 SHALL sample mode only at arbitration edges (IDLE grant, release, preemption); a change of mode never disturbs the current owner.
REQ-021 SHALL ensure gid and valid always agree with gnt in the same cycle.

Reset
REQ-022 SHALL, on rst high, immediately and asynchronously force gnt = 8'h00, gid = 3'b000, valid = 0, state IDLE, hcnt = 0, and last = 0 (the first round-robin search then starts at index 7).
REQ-023 SHALL, on rst asserted mid-grant, drop the grant without waiting for a clock edge and resume arbitration at the first rising edge after rst is released.

Verification
REQ-024 SHALL pass this check: mode = 0, req = 8'b0010_0100 -> one edge later gnt = 8'b0010_0000, gid = 3'b010, valid = 1.
REQ-025 SHALL pass this check: mode = 1, req = 8'hFF held, MAXHOLD = 8 -> grants to 7, 6, 5, ... 0, 7, each lasting 8 cycles, with gid stepping 0, 1, 2, ... 7, 0.
REQ-026 SHALL pass this check: owner 3 drops req[3] while req[1] = 1 -> at that edge gnt goes from 8'h08 to 8'h02 with no cycle of valid = 0.
REQ-027 SHALL pass this check: single requester req = 8'h01 held for 20 cycles -> gnt = 8'h01 throughout and hcnt saturates at MAXHOLD.
REQ-028 SHALL pass this check: rst pulsed mid-cycle during a grant -> gnt = 0 and valid = 0 before the next edge; with req = 8'h81 and mode = 1 after release -> first grant is gnt = 8'h80.
REQ-029 SHALL pass this check: req = 8'h00 after reset -> valid = 0 and gnt = 0 for all cycles.
